// File: rtl/priority_decoder_pkg.sv
// Shared types and constant helpers for the sequential one-hot priority decoder.
package priority_decoder_pkg;

    localparam int MAX_OUT = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Out-of-range indices decode to all-zero so the caller never sees a stray line.
    function automatic logic [MAX_OUT-1:0] onehot(input int idx, input int n);
        logic [MAX_OUT-1:0] r;
        r = '0;
        if (idx >= 0 && idx < n) r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/priority_decoder_seq_counter.sv
// Loadable down counter with zero flag; shared by the hold and gap phases.
module seq_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/priority_decoder_seq.sv
// Index -> one-hot line driver with programmable hold and break-before-make gap.
// Optional early release on ack is enabled by defining PRIORITY_DECODER_ACK_EN.
module priority_decoder_seq
    import priority_decoder_pkg::*;
#(
    parameter int N_OUT       = 8,
    parameter int IDX_W       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ack,
    output logic [N_OUT-1:0] D,
    output logic             busy,
    output logic             err
);

    localparam int             CW      = clog2(max3(HOLD_CYCLES, GAP_CYCLES, 2));
    localparam logic [CW-1:0]  HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           r_state, w_next_state;
    logic [N_OUT-1:0] r_d, w_d_next, w_onehot;
    logic             r_err, w_err_next;
    logic             w_load, w_dec, w_zero, w_ack, w_in_range;
    logic [CW-1:0]    w_load_val;

`ifdef PRIORITY_DECODER_ACK_EN
    assign w_ack = ack;
`else
    logic w_unused_ack;
    assign w_unused_ack = ack;
    assign w_ack        = 1'b0;
`endif

    assign w_in_range = int'(idx) < N_OUT;
    assign w_onehot   = N_OUT'(onehot(int'(idx), N_OUT));

    seq_down_counter #(.W(CW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_d_next     = r_d;
        w_err_next   = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_dec        = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_in_range) begin
                        w_d_next     = w_onehot;
                        w_next_state = ACTIVE;
                        w_load       = 1'b1;
                        w_load_val   = HOLD_LD;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // ack and terminal count share one exit path, so they never double-step.
                if (w_zero || w_ack) begin
                    w_d_next = '0;
                    if (GAP_CYCLES > 0) begin
                        w_next_state = GAP;
                        w_load       = 1'b1;
                        w_load_val   = GAP_LD;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            GAP: begin
                w_d_next = '0;
                if (w_zero) w_next_state = IDLE;
                else        w_dec        = 1'b1;
            end
            default: begin
                w_d_next     = '0;
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_d     <= w_d_next;
            r_err   <= w_err_next;
        end
    end

    assign in_ready = (r_state == IDLE) && !rst;
    assign busy     = (r_state != IDLE);
    assign D        = r_d;
    assign err      = r_err;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Scoreboard bench: stimulus pushes expected line/hold (or err) records, monitors pop on output activity.
module tb_priority_decoder_seq;

    localparam int HOLD = 4;
    localparam int GAPC = 1;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] idx8 = '0, idx6 = '0;
    logic       v8 = 1'b0, v6 = 1'b0, ack = 1'b0;
    logic       rdy8, rdy6, busy8, busy6, err8, err6;
    logic [7:0] d8;
    logic [5:0] d6;

    exp_t q8[$], q6[$];
    int   n_cmp = 0, n_err = 0;
    int   run8 = 0, run6 = 0, zeros8 = 100;
    logic [7:0] cur8 = '0, cur6 = '0;
    bit   gapchk = 1'b0;

    always #5 clk = ~clk;

    priority_decoder_seq #(.N_OUT(8), .IDX_W(3), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .rst(rst), .idx(idx8), .in_valid(v8), .in_ready(rdy8), .ack(ack),
        .D(d8), .busy(busy8), .err(err8));

    priority_decoder_seq #(.N_OUT(6), .IDX_W(3), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut6 (
        .clk(clk), .rst(rst), .idx(idx6), .in_valid(v6), .in_ready(rdy6), .ack(1'b0),
        .D(d6), .busy(busy6), .err(err6));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until accepted, then records what the monitor should observe.
    task automatic send(input bit six, input int ix, input exp_t e);
        bit acc;
        acc = 1'b0;
        if (six) begin idx6 = 3'(ix); v6 = 1'b1; end
        else     begin idx8 = 3'(ix); v8 = 1'b1; end
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = six ? rdy6 : rdy8;
            tick();
        end
        v6 = 1'b0;
        v8 = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
        else if (six) q6.push_back(e);
        else          q8.push_back(e);
    endtask

    task automatic wait_idle8();
        int k;
        k = 0;
        while ((busy8 || d8 != 0) && k < 50) begin tick(); k++; end
        if (k >= 50) check("idle_timeout", 0, 1);
        tick();
    endtask

    function automatic exp_t mk(input bit is_err, input logic [7:0] d, input int len);
        exp_t e;
        e.is_err = is_err; e.d = d; e.len = len;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        check("onehot8", 64'($countones(d8) <= 1), 1);
        if (err8) check("err8_spurious", err8, 0);
        if (d8 != 0) begin
            if (run8 == 0) begin
                cur8 = d8;
                // In steady back-to-back traffic the IDLE accept cycle follows the gap.
                if (gapchk) check("gap_len", zeros8, GAPC + 1);
            end else if (d8 != cur8) check("line_stable8", d8, cur8);
            run8++;
            zeros8 = 0;
        end else begin
            if (run8 != 0) begin
                if (q8.size() == 0) check("sb8_empty", 0, 1);
                else begin
                    e = q8.pop_front();
                    check("line8", cur8, e.d);
                    check("hold8", run8, e.len);
                end
            end
            run8 = 0;
            zeros8++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (err6) begin
            if (q6.size() == 0) check("sb6_empty", 0, 1);
            else begin
                e = q6.pop_front();
                check("err6_expected", 1, 64'(e.is_err));
            end
        end
        if (d6 != 0) begin
            if (run6 == 0) cur6 = 8'(d6);
            run6++;
        end else if (run6 != 0) begin
            if (q6.size() == 0) check("sb6_empty", 0, 1);
            else begin
                e = q6.pop_front();
                check("err6_kind", 64'(e.is_err), 0);
                check("line6", cur6, e.d);
                check("hold6", run6, e.len);
            end
            run6 = 0;
        end
    end

    initial begin
        int ex_ack;
        // Reset held two cycles
        tick();
        check("rst_d", d8, 0);
        check("rst_busy", busy8, 0);
        check("rst_err", err8, 0);
        check("rst_rdy", rdy8, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rdy_after_rst", rdy8, 1);
        check("rdy6_after_rst", rdy6, 1);

        // Basic decode idx=5 with gap timing
        send(1'b0, 5, mk(0, 8'b0010_0000, HOLD));
        check("basic_d_t1", d8, 8'b0010_0000);
        repeat (HOLD) tick();
        check("gap_d", d8, 0);
        check("gap_rdy", rdy8, 0);
        check("gap_busy", busy8, 1);
        tick();
        check("post_gap_rdy", rdy8, 1);
        check("post_gap_busy", busy8, 0);

        // Back-to-back sweep 0..7
        send(1'b0, 0, mk(0, 8'h01, HOLD));
        tick();
        gapchk = 1'b1;
        for (int i = 1; i < 8; i++) begin
            logic [7:0] one;
            one = 8'h01;
            send(1'b0, i, mk(0, one << i, HOLD));
        end
        wait_idle8();
        gapchk = 1'b0;

        // Out-of-range on the 6-line instance
        send(1'b1, 7, mk(1, 8'h00, 0));
        check("oor_err", err6, 1);
        check("oor_d", d6, 0);
        check("oor_rdy", rdy6, 1);
        tick();
        check("oor_err_1cyc", err6, 0);
        send(1'b1, 2, mk(0, 8'b0000_0100, HOLD));
        check("in6_d", d6, 6'b000100);
        repeat (HOLD + 2) tick();

        // Reset during the second ACTIVE cycle
        send(1'b0, 3, mk(0, 8'b0000_1000, 2));
        tick();
        rst = 1'b1;
        tick();
        check("midrst_d", d8, 0);
        check("midrst_busy", busy8, 0);
        rst = 1'b0;
        #1;
        check("midrst_rdy", rdy8, 1);
        tick();
        tick();

        // Early release via ack in the second ACTIVE cycle
`ifdef PRIORITY_DECODER_ACK_EN
        ex_ack = 2;
`else
        ex_ack = HOLD;
`endif
        send(1'b0, 1, mk(0, 8'b0000_0010, ex_ack));
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        wait_idle8();

        tick();
        check("sb8_drained", q8.size(), 0);
        check("sb6_drained", q6.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
